// File: rtl/strobe_tx_pkg.sv
// Shared FSM state type and width helpers for the strobe transmitter.
// Every strobe_tx file imports this package.
package strobe_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // GAP=0 still needs a one-bit counter so the port/net never collapses to zero width.
    function automatic int gap_cnt_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/strobe_tx_fifo.sv
// Synchronous FIFO for strobe_tx. The head word is presented combinationally,
// so a pop and a push in the same cycle are legal at any occupancy below DEPTH.
module strobe_tx_fifo
    import strobe_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/strobe_tx.sv
// Transmit side of the single-cycle valid-strobe interface: buffers upstream
// words and emits each one as a single strobe, with a minimum idle gap between strobes.
module strobe_tx
    import strobe_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              data_i,
    output logic                          valid_o,
    output logic [WIDTH-1:0]              data_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          idle_o
);

    localparam int GW = gap_cnt_width(GAP);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t           state;
    state_t           state_n;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_n;
    logic             pop;
    logic             valid_n;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    strobe_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (valid_i && ready_o),
        .wdata (data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready depends on occupancy alone, so there is no path from valid_i to ready_o.
    assign ready_o = !fifo_full;
    assign idle_o  = fifo_empty && (state == IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        pop     = 1'b0;
        valid_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    valid_n = 1'b1;
                    state_n = STROBE;
                end
            end
            STROBE: begin
                if (GAP > 0) begin
                    gap_n   = GAP_LOAD;
                    state_n = WAIT;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    valid_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                // The counter runs GAP-1 down to 0, giving exactly GAP idle cycles.
                if (gap_cnt == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        valid_n = 1'b1;
                        state_n = STROBE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            gap_cnt <= '0;
        end else begin
            valid_o <= valid_n;
            gap_cnt <= gap_n;
            if (pop) begin
                data_o <= fifo_rdata;
            end
        end
    end

endmodule

// File: tb/tb_strobe_tx.sv
// Bench for strobe_tx: three instances (GAP 0, 2, 3) share one random stream;
// each instance keeps a scoreboard of accepted words and their earliest legal strobe edge.
module tb_strobe_tx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [7:0] d;
        int         e;
    } item_t;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i  = '0;
    logic       done    = 1'b0;
    int         cyc     = 0;
    int         check_count = 0;
    int         fail_count  = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(posedge clk_i);
        #1;
        valid_i = v;
        data_i  = d;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int GAP = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

        logic          ready_o;
        logic          valid_o;
        logic          idle_o;
        logic [7:0]    data_o;
        logic [CW-1:0] count_o;
        item_t         q[$];
        item_t         head;
        int            prev = -1000;
        int            n_model;
        logic [7:0]    last = '0;

        strobe_tx #(
            .WIDTH (8),
            .DEPTH (DEPTH),
            .GAP   (GAP)
        ) dut (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (valid_i),
            .ready_o (ready_o),
            .data_i  (data_i),
            .valid_o (valid_o),
            .data_o  (data_o),
            .count_o (count_o),
            .idle_o  (idle_o)
        );

        // A word seen with valid_i && ready_o here is captured by the next edge.
        always @(posedge clk_i) begin
            #3;
            if (!rst_i && valid_i && ready_o) begin
                q.push_back('{d: data_i, e: cyc + 1});
            end
        end

        // Strobe edge = max(previous strobe + GAP + 1, capture edge + 1).
        always @(negedge clk_i) begin
            if (!rst_i) begin
                if (valid_o) begin
                    if (q.size() == 0) begin
                        checkOutput($sformatf("gap%0d spurious strobe", GAP), int'(valid_o), 0);
                    end else begin
                        head = q.pop_front();
                        checkOutput($sformatf("gap%0d strobe data", GAP), int'(data_o), int'(head.d));
                        checkOutput($sformatf("gap%0d strobe edge", GAP), cyc, imax(prev + GAP + 1, head.e + 1));
                        prev = cyc;
                        last = head.d;
                    end
                end else begin
                    checkOutput($sformatf("gap%0d held data", GAP), int'(data_o), int'(last));
                    if (q.size() > 0 && imax(prev + GAP + 1, q[0].e + 1) == cyc) begin
                        checkOutput($sformatf("gap%0d missing strobe", GAP), int'(valid_o), 1);
                    end
                end
                n_model = 0;
                foreach (q[i]) begin
                    if (q[i].e <= cyc) n_model++;
                end
                checkOutput($sformatf("gap%0d count", GAP), int'(count_o), n_model);
                checkOutput($sformatf("gap%0d ready", GAP), int'(ready_o), int'(n_model != DEPTH));
            end
        end

        // Asynchronous reset discards everything the model had queued.
        always @(posedge rst_i) begin
            #1;
            q.delete();
            prev = -1000;
            last = '0;
            checkOutput($sformatf("gap%0d reset valid", GAP), int'(valid_o), 0);
            checkOutput($sformatf("gap%0d reset data", GAP), int'(data_o), 0);
            checkOutput($sformatf("gap%0d reset count", GAP), int'(count_o), 0);
            checkOutput($sformatf("gap%0d reset ready", GAP), int'(ready_o), 1);
            checkOutput($sformatf("gap%0d reset idle", GAP), int'(idle_o), 1);
        end

        always @(posedge done) begin
            checkOutput($sformatf("gap%0d undelivered words", GAP), q.size(), 0);
            checkOutput($sformatf("gap%0d final count", GAP), int'(count_o), 0);
            checkOutput($sformatf("gap%0d final idle", GAP), int'(idle_o), 1);
        end
    end

    initial begin
        $display("[TB] strobe_tx bench start");
        idleCycles(2);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;

        // Single word latency
        applyStimulus(1'b1, 8'hA5);
        idleCycles(8);

        // Consecutive pushes
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h03);
        idleCycles(14);
        applyStimulus(1'b1, 8'h10);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h12);
        idleCycles(14);

        // Sustained valid fills the slower instances
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i));
        end
        idleCycles(24);

        // Reset with words still queued
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i));
        end
        @(posedge clk_i);
        #2;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        idleCycles(8);

        // Random traffic, exercising pointer wrap and same-cycle push/pop
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
        end
        idleCycles(60);

        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/strobe_tx.md
Name: strobe_tx

Overview:
- Transmit side of the single-cycle valid-strobe interface. Downstream, a sampling holding buffer latches data on each valid strobe and passes data through combinationally while the strobe is high.
- Accepts words from an upstream ready/valid stream into a small FIFO. Each word is emitted as exactly one single-cycle valid_o strobe with data_o.
- A programmable minimum idle gap is enforced between strobes so slow downstream sinks are never overrun.
- data_o holds the last emitted word between strobes.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- GAP, 0, minimum idle cycles between consecutive strobes; 0 allows back-to-back strobes.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  upstream may push; a transfer occurs when valid_i && ready_o at a clock edge.
- data_i  input  WIDTH  upstream word.
- valid_o  output  1  single-cycle strobe to the downstream sink.
- data_o  output  WIDTH  strobed word; held stable between strobes.
- count_o  output  $clog2(DEPTH+1)  current FIFO occupancy.
- idle_o  output  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (rst_i high, asynchronous):
  - FIFO pointers and count cleared; FSM goes to IDLE; gap counter cleared.
  - valid_o=0, data_o='0, count_o=0, ready_o=1, idle_o=1.
- Reset mid-operation discards all queued words and any pending gap; no strobe is issued in the cycle after deassertion.
- ready_o = (count != DEPTH). It depends only on occupancy:
  - when full, ready_o=0 even if a pop occurs the same cycle;
  - no combinational path from valid_i to ready_o.
- Push: on an edge with valid_i && ready_o, data_i is written at the write pointer and the pointer wraps modulo DEPTH.
- Pop: occurs when the FSM issues a strobe. The head is read and the read pointer wraps modulo DEPTH.
- Count update rules:
  - push without pop: count+1;
  - pop without push: count-1;
  - push and pop together: count unchanged.
- Simultaneous push and pop are legal at any occupancy below DEPTH, including 1 (FIFO read-before-write).
- FSM states (enum):
  - IDLE: if count>0, pop the head, register it to data_o, set valid_o=1 next cycle, go to STROBE. Otherwise stay.
  - STROBE: valid_o is high for exactly this cycle.
    - If GAP>0: load gap counter with GAP-1 and go to WAIT.
    - If GAP==0 and count>0: pop again so the strobe repeats next cycle, stay in STROBE.
    - Otherwise go to IDLE.
  - WAIT: valid_o=0; decrement the counter. At 0, go to IDLE if the FIFO is empty, or pop and go to STROBE if not. This gives exactly GAP idle cycles.
- Registering rules:
  - valid_o and data_o are registered.
  - data_o changes only in a cycle where valid_o=1.
  - valid_o is never high for two consecutive cycles when GAP>0.
- Latency: a word accepted on edge k into an empty FIFO with the FSM in IDLE appears with valid_o=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput:
  - 1 word/cycle when GAP=0;
  - 1 word per (GAP+1) cycles otherwise.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- Gap counter width is $clog2(GAP+1), minimum 1 bit.

Decomposition:
- Package strobe_tx_pkg holds the FSM state typedef (IDLE, STROBE, WAIT) and width helper constants.
- Sub-module strobe_tx_fifo(WIDTH, DEPTH) provides the synchronous FIFO: push/pop, count, full/empty, and the same clock and asynchronous reset.
- FSM, gap counter and output registers live in strobe_tx.

Test Plan:
- Reset: rst_i=1 asynchronously mid-stream with 3 words queued → valid_o=0, data_o=0, count_o=0, ready_o=1 immediately; no strobe after release.
- Latency, GAP=0: push 0xA5 at edge 1 into an empty FIFO → valid_o=1 with data_o=0xA5 in the cycle after edge 2; data_o holds 0xA5 afterwards while valid_o=0.
- Back-to-back, GAP=0: push 0x01,0x02,0x03 on consecutive edges → three consecutive valid_o cycles carrying 0x01, 0x02, 0x03 in order.
- Gap, GAP=2: push 0x10,0x11,0x12 at once → strobes spaced by exactly 2 idle cycles (pattern 1,0,0,1,0,0,1); count_o decrements at each strobe.
- Full: DEPTH=4, GAP=3, hold valid_i=1 with 0x20..0x27 → ready_o drops once count_o=4; it re-asserts only after a pop; all accepted words are strobed in order, none lost.
- Wrap and simultaneous push/pop: stream 20 words at random valid_i with GAP=0 → pointers wrap repeatedly, count_o is stable on same-cycle push/pop, and the output sequence matches the input sequence; idle_o=1 at the end.
